// File: rtl/bpsk_frame_controller.sv
// bpsk_frame_controller
//   Receive-path sequencer between the BPSK bit demodulator and a byte consumer.
//   It waits for demodulator lock, hunts for SYNC_WORD, captures a length byte, then
//   packs payload bits MSB-first into bytes and queues them in a FIFO. A bit-gap timer
//   and a lock monitor abort stalled or broken frames.
//   Optional macro BPSK_FRAME_CRC8_EN: a CRC-8 byte (poly 0x07, init 0) over the length
//   byte and the payload follows the payload and is checked before frame_done.
// Ports
//   clock, reset     : system clock, asynchronous active-high reset
//   enable           : run; low forces IDLE and flushes the FIFO
//   lock             : demodulator lock
//   bit_in/bit_valid : demodulated bit and its 1-cycle strobe
//   demod_clear      : 1-cycle integrator reset request to the demodulator
//   out_data/out_valid/out_ready : FIFO head, valid/ready handshake
//   frame_len        : length byte of the most recent frame
//   frame_start/frame_done/frame_error : 1-cycle frame event pulses
//   busy             : frame reception in progress (SYNC..CHECK)
module bpsk_frame_controller #(
    parameter logic [15:0] SYNC_WORD      = 16'hA5C3,
    parameter int          FIFO_DEPTH     = 4,
    parameter int          TIMEOUT_CYCLES = 4096
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       lock,
    input  logic       bit_in,
    input  logic       bit_valid,
    output logic       demod_clear,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] frame_len,
    output logic       frame_start,
    output logic       frame_done,
    output logic       frame_error,
    output logic       busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {IDLE, HUNT, SYNC, LENGTH, PAYLOAD, CHECK, DONE} state_t;

`ifdef BPSK_FRAME_CRC8_EN
    localparam state_t TAIL = CHECK;
`else
    localparam state_t TAIL = DONE;
`endif

    state_t        state, nstate;
    logic [15:0]   shreg;
    logic [4:0]    sync_cnt;       // bits seen since SYNC entry, saturates at 16
    logic [7:0]    byte_sr;
    logic [2:0]    bcnt;
    logic [7:0]    bytes_left;
    logic [15:0]   tmo;
    logic          push_pend;      // byte completed last cycle, written this cycle
    logic [7:0]    push_data;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] cnt;
`ifdef BPSK_FRAME_CRC8_EN
    logic [7:0]    crc, crc_nx;
`endif

    logic [15:0] shreg_nx;
    logic [7:0]  byte_nx;
    logic        byte_end, in_frame, pop, push, full, overflow, abort, flush;
    logic        start_evt, done_evt, err_evt, clr_evt;

    assign shreg_nx = {shreg[14:0], bit_in};
    assign byte_nx  = {byte_sr[6:0], bit_in};
    assign byte_end = bit_valid && (bcnt == 3'd7);
    assign in_frame = (state == SYNC) || (state == LENGTH) || (state == PAYLOAD) || (state == CHECK);
    assign busy     = in_frame;
    assign out_valid = (cnt != '0);
    assign out_data  = mem[rd_ptr];
    assign pop      = out_valid && out_ready;
    assign full     = (cnt == CW'(FIFO_DEPTH));
    assign overflow = push_pend && full && !pop;
    assign push     = push_pend && !overflow;
    assign abort    = in_frame && (!lock || (tmo >= TMO_LIMIT) || overflow);
    assign flush    = !enable || overflow;

`ifdef BPSK_FRAME_CRC8_EN
    assign crc_nx = {crc[6:0], 1'b0} ^ ((crc[7] ^ bit_in) ? 8'h07 : 8'h00);
`endif

    always_comb begin
        nstate    = state;
        start_evt = 1'b0;
        err_evt   = 1'b0;
        clr_evt   = 1'b0;
        if (!enable) begin
            nstate = IDLE;
        end else if (abort) begin
            nstate  = HUNT;
            err_evt = 1'b1;
            clr_evt = 1'b1;
        end else begin
            case (state)
                IDLE: nstate = HUNT;
                HUNT: if (lock) begin
                    nstate  = SYNC;
                    clr_evt = 1'b1;
                end
                SYNC: if (bit_valid && sync_cnt >= 5'd15 && shreg_nx == SYNC_WORD) begin
                    nstate    = LENGTH;
                    start_evt = 1'b1;
                end
                LENGTH: if (byte_end) nstate = (byte_nx != 8'd0) ? PAYLOAD : TAIL;
                // leave only once the last byte has actually been written
                PAYLOAD: if (push_pend && bytes_left == 8'd0) nstate = TAIL;
`ifdef BPSK_FRAME_CRC8_EN
                CHECK: if (byte_end) begin
                    if (byte_nx == crc) begin
                        nstate = DONE;
                    end else begin
                        nstate  = HUNT;
                        err_evt = 1'b1;
                        clr_evt = 1'b1;
                    end
                end
`endif
                DONE:    nstate = HUNT;
                default: nstate = IDLE;
            endcase
        end
        done_evt = (nstate == DONE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            shreg       <= '0;
            sync_cnt    <= '0;
            byte_sr     <= '0;
            bcnt        <= '0;
            bytes_left  <= '0;
            tmo         <= '0;
            push_pend   <= 1'b0;
            push_data   <= '0;
            frame_len   <= '0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            frame_error <= 1'b0;
            demod_clear <= 1'b0;
`ifdef BPSK_FRAME_CRC8_EN
            crc         <= '0;
`endif
        end else begin
            state       <= nstate;
            frame_start <= start_evt;
            frame_done  <= done_evt;
            frame_error <= err_evt;
            demod_clear <= clr_evt;

            if (bit_valid || nstate != state)
                tmo <= '0;
            else if (tmo != 16'hFFFF)
                tmo <= tmo + 16'd1;

            // every state change restarts bit collection from scratch
            if (nstate != state) begin
                shreg    <= '0;
                sync_cnt <= '0;
                byte_sr  <= '0;
                bcnt     <= '0;
            end else if (bit_valid) begin
                if (state == SYNC) begin
                    shreg <= shreg_nx;
                    if (sync_cnt != 5'd16) sync_cnt <= sync_cnt + 5'd1;
                end
                if (state == LENGTH || state == PAYLOAD || state == CHECK) begin
                    byte_sr <= byte_nx;
                    bcnt    <= bcnt + 3'd1;
                end
            end

            if (state == LENGTH && byte_end && (nstate == PAYLOAD || nstate == TAIL)) begin
                frame_len  <= byte_nx;
                bytes_left <= byte_nx;
            end

            push_pend <= (state == PAYLOAD) && byte_end && (nstate == PAYLOAD);
            if (state == PAYLOAD && byte_end && nstate == PAYLOAD) begin
                push_data  <= byte_nx;
                bytes_left <= bytes_left - 8'd1;
            end

`ifdef BPSK_FRAME_CRC8_EN
            if (state == SYNC)
                crc <= '0;
            else if (bit_valid && (state == LENGTH || (state == PAYLOAD && nstate == PAYLOAD)))
                crc <= crc_nx;
`endif
        end
    end

    // Payload FIFO; push and pop may coincide even when full
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end
endmodule
